// File: rtl/qsys_nios2_qsys_dct_ctrl.sv
// OCI compressed-trace packing sequencer: packs 2-bit trace symbols, hands full or
// flushed buffers to the trace-memory port, and runs the end-of-test drain.
module qsys_nios2_qsys_dct_ctrl #(
  parameter int MAX_SYMS  = 15,
  parameter int FRM_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sym_valid,
  input  logic [1:0]           sym_data,
  output logic                 sym_ready,
  input  logic                 flush_req,
  input  logic                 test_ending,
  output logic                 frm_valid,
  output logic [33:0]          frm_data,
  input  logic                 frm_ready,
  output logic [29:0]          dct_buffer,
  output logic [3:0]           dct_count,
  output logic                 test_has_ended,
  output logic [FRM_CNT_W-1:0] frm_count
);

  localparam logic [3:0]           MAX_CNT = 4'(MAX_SYMS);
  localparam logic [FRM_CNT_W-1:0] CNT_ONE = {{(FRM_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ENDED = 2'd2
  } state_t;

  // Writes symbol sym into slot idx of the packing buffer, leaving other slots intact.
  function automatic logic [29:0] pack_sym(input logic [29:0] pack_in,
                                           input logic [3:0]  idx,
                                           input logic [1:0]  sym);
    logic [29:0] res;
    res = pack_in;
    for (int i = 0; i < 15; i++) begin
      res[2*i +: 2] = (idx == 4'(i)) ? sym : res[2*i +: 2];
    end
    return res;
  endfunction

  state_t                 state_r, state_nx_s;
  logic [29:0]            buf_r, buf_nx_s;
  logic [3:0]             cnt_r, cnt_nx_s;
  logic                   frm_valid_r, frm_valid_nx_s;
  logic [33:0]            frm_data_r, frm_data_nx_s;
  logic                   flush_pend_r, flush_pend_nx_s;
  logic                   ended_r;
  logic [FRM_CNT_W-1:0]   frm_cnt_r, frm_cnt_nx_s;
  logic                   ob_free_s, sym_ready_s, accept_s, xfer_s, frm_take_s;

  // Handshake decode; sym_ready is a function of registered state only.
  always_comb begin
    frm_take_s  = frm_valid_r && frm_ready;
    ob_free_s   = !frm_valid_r || frm_ready;
    sym_ready_s = (state_r == ST_RUN) && !flush_pend_r && (cnt_r < MAX_CNT);
    accept_s    = sym_valid && sym_ready_s;
    xfer_s      = ob_free_s && (cnt_r != 4'd0) &&
                  ((cnt_r == MAX_CNT) || flush_pend_r || (state_r == ST_DRAIN));
  end

  // Next-state logic for the run/drain/ended sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (test_ending) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if ((cnt_r == 4'd0) && ob_free_s) begin
          state_nx_s = ST_ENDED;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_ENDED: state_nx_s = ST_ENDED;
      default:  state_nx_s = ST_RUN;
    endcase
  end

  // Next values for the packing buffer, output register, flush flag and frame counter.
  always_comb begin
    buf_nx_s        = buf_r;
    cnt_nx_s        = cnt_r;
    frm_valid_nx_s  = frm_valid_r;
    frm_data_nx_s   = frm_data_r;
    flush_pend_nx_s = flush_pend_r;
    frm_cnt_nx_s    = frm_cnt_r;

    // A transfer and a symbol accept are mutually exclusive by construction of sym_ready.
    if (xfer_s) begin
      buf_nx_s = 30'd0;
      cnt_nx_s = 4'd0;
    end else if (accept_s) begin
      buf_nx_s = pack_sym(buf_r, cnt_r, sym_data);
      cnt_nx_s = cnt_r + 4'd1;
    end else begin
      buf_nx_s = buf_r;
      cnt_nx_s = cnt_r;
    end

    if (xfer_s) begin
      frm_valid_nx_s = 1'b1;
      frm_data_nx_s  = {cnt_r, buf_r};
    end else if (frm_take_s) begin
      frm_valid_nx_s = 1'b0;
    end else begin
      frm_valid_nx_s = frm_valid_r;
    end

    // An empty-buffer flush retires on the following edge without producing a frame.
    if (xfer_s) begin
      flush_pend_nx_s = 1'b0;
    end else if (flush_pend_r && (cnt_r == 4'd0)) begin
      flush_pend_nx_s = 1'b0;
    end else if (flush_req && (state_r == ST_RUN)) begin
      flush_pend_nx_s = 1'b1;
    end else begin
      flush_pend_nx_s = flush_pend_r;
    end

    if (frm_take_s) begin
      frm_cnt_nx_s = frm_cnt_r + CNT_ONE;
    end else begin
      frm_cnt_nx_s = frm_cnt_r;
    end
  end

  // State and datapath registers; reset discards any buffered or pending frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_RUN;
      buf_r        <= 30'd0;
      cnt_r        <= 4'd0;
      frm_valid_r  <= 1'b0;
      frm_data_r   <= 34'd0;
      flush_pend_r <= 1'b0;
      ended_r      <= 1'b0;
      frm_cnt_r    <= {FRM_CNT_W{1'b0}};
    end else begin
      state_r      <= state_nx_s;
      buf_r        <= buf_nx_s;
      cnt_r        <= cnt_nx_s;
      frm_valid_r  <= frm_valid_nx_s;
      frm_data_r   <= frm_data_nx_s;
      flush_pend_r <= flush_pend_nx_s;
      ended_r      <= (state_nx_s == ST_ENDED);
      frm_cnt_r    <= frm_cnt_nx_s;
    end
  end

  assign sym_ready      = sym_ready_s;
  assign frm_valid      = frm_valid_r;
  assign frm_data       = frm_data_r;
  assign dct_buffer     = buf_r;
  assign dct_count      = cnt_r;
  assign test_has_ended = ended_r;
  assign frm_count      = frm_cnt_r;

endmodule

// File: tb/tb_qsys_nios2_qsys_dct_ctrl.sv
// Scoreboard bench for the DCT packing sequencer: directed stimulus pushes expected
// frames, a negedge monitor pops and compares each frame the trace-memory port accepts.
module tb_qsys_nios2_qsys_dct_ctrl;

  localparam int CW = 4;  // narrow frame counter so the wrap is reachable quickly

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sym_valid = 1'b0;
  logic [1:0]    sym_data = 2'd0;
  logic          flush_req = 1'b0;
  logic          test_ending = 1'b0;
  logic          frm_ready = 1'b0;
  logic          sym_ready, frm_valid, test_has_ended;
  logic [33:0]   frm_data;
  logic [29:0]   dct_buffer;
  logic [3:0]    dct_count;
  logic [CW-1:0] frm_count;

  int checks = 0;
  int failures = 0;
  logic [33:0]   sb_q[$];
  logic [CW-1:0] mdl_cnt = '0;

  qsys_nios2_qsys_dct_ctrl #(.MAX_SYMS(15), .FRM_CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready), .flush_req(flush_req), .test_ending(test_ending),
    .frm_valid(frm_valid), .frm_data(frm_data), .frm_ready(frm_ready),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_has_ended(test_has_ended),
    .frm_count(frm_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted frame must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb_q.delete();
      mdl_cnt = '0;
    end else if (frm_valid && frm_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got %0h expected no frame at %0t", frm_data, $time);
      end else begin
        check("frame", frm_data, sb_q.pop_front());
        check("frm_count_before_accept", frm_count, mdl_cnt);
        mdl_cnt = mdl_cnt + CW'(1);
      end
    end
  end

  task automatic send_sym(input logic [1:0] d, input logic fl);
    sym_valid = 1'b1;
    sym_data  = d;
    flush_req = fl;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sym_ready) begin
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        flush_req = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    sym_valid = 1'b0;
    flush_req = 1'b0;
    checks++;
    failures++;
    $display("FAIL send_timeout: got sym_ready=0 expected 1 within 200 cycles");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0) return;
      @(posedge clk);
      #2;
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout: got %0d frames left expected 0", sb_q.size());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #22;
    check("rst_frm_valid", frm_valid, 0);
    check("rst_frm_data", frm_data, 0);
    check("rst_dct_buffer", dct_buffer, 0);
    check("rst_dct_count", dct_count, 0);
    check("rst_frm_count", frm_count, 0);
    check("rst_test_has_ended", test_has_ended, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_sym_ready", sym_ready, 1);

    // 1: full frame, symbols 3,2,1,0 repeating packed LSB first
    @(posedge clk); #1;
    frm_ready = 1'b1;
    sb_q.push_back({4'd15, 30'h1B1B1B1B});
    for (int i = 0; i < 15; i++) send_sym(2'(3 - (i % 4)), 1'b0);
    check("t1_count_full", dct_count, 15);
    check("t1_ready_full", sym_ready, 0);
    wait_drain();
    check("t1_count_empty", dct_count, 0);
    check("t1_frm_count", frm_count, 1);

    // 2: stalled output register with a second full frame behind it
    frm_ready = 1'b0;
    sb_q.push_back({4'd15, 30'h15555555});
    for (int i = 0; i < 15; i++) send_sym(2'd1, 1'b0);
    sb_q.push_back({4'd15, 30'h2AAAAAAA});
    for (int i = 0; i < 15; i++) send_sym(2'd2, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t2_ready_stall", sym_ready, 0);
    check("t2_count_stall", dct_count, 15);
    check("t2_valid_stall", frm_valid, 1);
    check("t2_data_stall", frm_data, {4'd15, 30'h15555555});
    @(posedge clk); #1;
    frm_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t2_no_gap_valid", frm_valid, 1);
    check("t2_no_gap_data", frm_data, {4'd15, 30'h2AAAAAAA});
    wait_drain();
    check("t2_frm_count", frm_count, 3);

    // 3: flush with the third symbol, then a flush of an empty buffer
    sb_q.push_back({4'd3, 30'h1B});
    send_sym(2'd3, 1'b0);
    send_sym(2'd2, 1'b0);
    send_sym(2'd1, 1'b1);
    wait_drain();
    check("t3_count", dct_count, 0);
    @(posedge clk); #1;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    check("t3_flush_pend_set", sym_ready, 0);
    @(posedge clk); #1;
    check("t3_flush_pend_clear", sym_ready, 1);
    repeat (3) @(negedge clk);
    check("t3_no_empty_frame", frm_valid, 0);

    // 4: end-of-test drain behind a stalled frame
    @(posedge clk); #1;
    frm_ready = 1'b0;
    sb_q.push_back({4'd2, 30'hF});
    send_sym(2'd3, 1'b0);
    send_sym(2'd3, 1'b1);
    sb_q.push_back({4'd5, 30'h0E4});
    send_sym(2'd0, 1'b0);
    send_sym(2'd1, 1'b0);
    send_sym(2'd2, 1'b0);
    send_sym(2'd3, 1'b0);
    send_sym(2'd0, 1'b0);
    test_ending = 1'b1;
    @(posedge clk); #1;
    test_ending = 1'b0;
    check("t4_drain_ready", sym_ready, 0);
    check("t4_drain_count", dct_count, 5);
    repeat (3) @(posedge clk);
    #1;
    check("t4_stall_count", dct_count, 5);
    check("t4_not_ended", test_has_ended, 0);
    frm_ready = 1'b1;
    wait_drain();
    check("t4_ended", test_has_ended, 1);
    check("t4_valid_after", frm_valid, 0);
    sym_valid = 1'b1;
    flush_req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    sym_valid = 1'b0;
    flush_req = 1'b0;
    check("t4_ended_ready", sym_ready, 0);
    check("t4_ended_count", dct_count, 0);
    check("t4_ended_valid", frm_valid, 0);
    check("t4_ended_sticky", test_has_ended, 1);

    // 5: asynchronous reset with a frame pending
    reset_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    sb_q.push_back({4'd1, 30'h1});
    send_sym(2'd1, 1'b1);
    wait_drain();
    frm_ready = 1'b0;
    send_sym(2'd2, 1'b1);
    send_sym(2'd1, 1'b0);
    send_sym(2'd3, 1'b0);
    @(posedge clk); #3;
    check("t5_pre_valid", frm_valid, 1);
    check("t5_pre_frm_count", frm_count, 1);
    reset_n = 1'b0;
    #1;
    check("t5_async_valid", frm_valid, 0);
    check("t5_async_data", frm_data, 0);
    check("t5_async_buffer", dct_buffer, 0);
    check("t5_async_count", dct_count, 0);
    check("t5_async_frm_count", frm_count, 0);
    check("t5_async_ended", test_has_ended, 0);
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    frm_ready = 1'b1;
    sb_q.push_back({4'd15, 30'h3FFFFFFF});
    for (int i = 0; i < 15; i++) send_sym(2'd3, 1'b0);
    wait_drain();
    check("t5_fresh_frm_count", frm_count, 1);
    check("t5_fresh_count", dct_count, 0);

    // 6: frame counter wrap
    for (int i = 0; i < 14; i++) begin
      sb_q.push_back({4'd1, 28'd0, 2'(i % 4)});
      send_sym(2'(i % 4), 1'b1);
      wait_drain();
    end
    check("t6_cnt_max", frm_count, 4'hF);
    sb_q.push_back({4'd1, 30'h2});
    send_sym(2'd2, 1'b1);
    wait_drain();
    check("t6_cnt_wrap", frm_count, 0);
    check("t6_count", dct_count, 0);
    check("t6_valid", frm_valid, 0);
    check("t6_ended", test_has_ended, 0);
    check("t6_ready", sym_ready, 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
